// File: rtl/sram_pkg.sv
// Shared definitions for the on-chip model of the 256K x 16 asynchronous SRAM.
// Holds the responder state encoding, the byte-lane index constants and the
// pin-bus widths used by sram_responder and sram_resp_mem.
package sram_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 18;

  // Byte-lane positions in the lane mask / drive vector.
  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RD_DRIVE
  } sram_state_e;

endpackage

// File: rtl/sram_resp_mem.sv
// Byte-lane storage for the SRAM responder: two 8-bit DEPTH-entry banks with
// independent write enables and one synchronous (registered) read port, so the
// array maps onto FPGA block RAM. Contents are never reset.
// Ports:
//   clk      in   clock
//   wr_en    in   [1:0] per-lane write enable (bit LANE_LO = [7:0])
//   wr_addr  in   write word address
//   wr_data  in   write data
//   rd_addr  in   read word address
//   rd_data  out  registered read data, valid one cycle after rd_addr
module sram_resp_mem
  import sram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [1:0]        wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [7:0] bank_lo [DEPTH];
  logic [7:0] bank_hi [DEPTH];

  // Read-first behaviour: a write and a read to the same word in one cycle
  // returns the old contents; the responder's read latency hides this.
  always_ff @(posedge clk) begin
    if (wr_en[LANE_LO]) begin
      bank_lo[wr_addr] <= wr_data[7:0];
    end
    if (wr_en[LANE_HI]) begin
      bank_hi[wr_addr] <= wr_data[15:8];
    end
    rd_data <= {bank_hi[rd_addr], bank_lo[rd_addr]};
  end

endmodule

// File: rtl/sram_responder.sv
// Cycle-defined stand-in for the external 256K x 16 asynchronous SRAM. Decodes
// CE/WE/OE/LB/UB on every rising clock, commits byte-lane writes when the write
// strobe ends, and drives the data bus on reads after RD_LAT cycles of a stable
// request.
// Ports:
//   i_clk        in     clock shared with the SRAM controller
//   i_rst        in     synchronous active-high reset
//   i_sram_addr  in     [17:0] word address (aliases modulo DEPTH)
//   io_sram_dq   inout  [15:0] data bus, high-Z unless driving
//   i_sram_ce_n  in     chip enable, active low
//   i_sram_we_n  in     write enable, active low
//   i_sram_oe_n  in     output enable, active low
//   i_sram_lb_n  in     low byte enable, active low
//   i_sram_ub_n  in     high byte enable, active low
//   o_drive      out    [1:0] per-lane drive enable (bit0 low byte)
//   o_wr_cnt     out    [15:0] committed write count, wraps
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_dq,
  input  logic              i_sram_ce_n,
  input  logic              i_sram_we_n,
  input  logic              i_sram_oe_n,
  input  logic              i_sram_lb_n,
  input  logic              i_sram_ub_n,
  output logic [1:0]        o_drive,
  output logic [15:0]       o_wr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RD_LAT);

  sram_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        drive_q, drive_d;
  logic [AW-1:0]     cap_addr_q;
  logic [DATA_W-1:0] cap_data_q;
  logic [1:0]        cap_mask_q;
  logic [ADDR_W-1:0] prev_addr_q;
  logic [1:0]        prev_mask_q;
  logic [15:0]       wr_cnt_q;

  logic              wr_req, rd_req, req_changed;
  logic              capture, commit;
  logic [1:0]        lane_mask;
  logic [1:0]        mem_wr_en;
  logic [DATA_W-1:0] mem_rd_data;

  // WE overrides OE: a cycle with both low is a write, never a read.
  assign wr_req      = !i_sram_ce_n && !i_sram_we_n;
  assign rd_req      = !i_sram_ce_n && i_sram_we_n && !i_sram_oe_n;
  assign lane_mask   = {!i_sram_ub_n, !i_sram_lb_n};
  assign req_changed = (i_sram_addr != prev_addr_q) || (lane_mask != prev_mask_q);

  // Gated by reset so a reset landing on the commit cycle cannot write memory.
  assign mem_wr_en = (commit && !i_rst) ? cap_mask_q : 2'b00;

  sram_resp_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (mem_wr_en),
    .wr_addr (cap_addr_q),
    .wr_data (cap_data_q),
    .rd_addr (i_sram_addr[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // The memory read port follows the live address every cycle; by the time the
  // counter expires the registered data matches the held address, including any
  // write committed at the start of the read window.
  assign io_sram_dq = {drive_q[LANE_HI] ? mem_rd_data[15:8] : 8'hzz,
                       drive_q[LANE_LO] ? mem_rd_data[7:0]  : 8'hzz};
  assign o_drive    = drive_q;
  assign o_wr_cnt   = wr_cnt_q;

  // Next-state, latency counter and registered drive enable. The drive vector
  // is computed for the state being entered, so release happens on the same
  // edge that samples the terminating condition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drive_d = 2'b00;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WRITE;
          capture = 1'b1;
        end else if (rd_req) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      WRITE: begin
        if (wr_req) begin
          capture = 1'b1;
        end else begin
          commit = 1'b1;
          if (rd_req) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RD_WAIT: begin
        if (wr_req) begin
          state_d = WRITE;
          capture = 1'b1;
        end else if (!rd_req) begin
          state_d = IDLE;
        end else if (req_changed) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RD_DRIVE;
          drive_d = lane_mask;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_DRIVE: begin
        if (wr_req) begin
          state_d = WRITE;
          capture = 1'b1;
        end else if (!rd_req) begin
          state_d = IDLE;
        end else if (req_changed) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          drive_d = lane_mask;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, capture and counter registers. Memory contents are not reset; the
  // capture is cleared so a write interrupted by reset is simply dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drive_q     <= 2'b00;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      cap_mask_q  <= 2'b00;
      prev_addr_q <= '0;
      prev_mask_q <= 2'b00;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drive_q     <= drive_d;
      prev_addr_q <= i_sram_addr;
      prev_mask_q <= lane_mask;
      if (capture) begin
        cap_addr_q <= i_sram_addr[AW-1:0];
        cap_data_q <= io_sram_dq;
        cap_mask_q <= lane_mask;
      end
      if (commit) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

endmodule
